// File: rtl/audio_note_sequencer.sv
// audio_note_sequencer: FIFO-fed square-wave note player that drives the PWM duty.
// Ports: clk/reset_n, wr_en/wr_data note push, clear flush, duty_cycle/note_done/busy, FIFO status.
module audio_note_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TICK_DIV   = 50000,
  parameter logic [9:0]  AMPLITUDE  = 10'd512
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_data,
  input  logic                          clear,
  output logic [9:0]                    duty_cycle,
  output logic                          note_done,
  output logic                          busy,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY
  } state_e;

  // FIFO storage and bookkeeping
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;
  logic [LW-1:0] level_q;
  logic          empty_q;
  logic          full_q;
  logic          ovf_q;

  logic          full_int;
  logic          avail;
  logic          push;
  logic          pop;
  logic [31:0]   head;

  // Player state
  state_e        state_q;
  logic [15:0]   hp_q;
  logic [15:0]   rem_q;
  logic [15:0]   phase_q;
  logic [PW-1:0] presc_q;
  logic          square_q;
  logic [9:0]    duty_q;
  logic          done_q;
  logic          busy_q;

  logic          tick_wrap;
  logic          ph_wrap;
  logic          sq_nx;
  logic          play_end;

  // cnt_q is the live occupancy; the exported flags lag it by one edge.
  // Push gating uses the live count so back-to-back writes never overrun.
  assign full_int = (cnt_q == LW'(FIFO_DEPTH));
  assign avail    = (cnt_q != '0);
  assign push     = wr_en && !full_int && !clear;
  assign head     = mem_q[rd_ptr_q];

  assign tick_wrap = (presc_q == PW'(TICK_DIV - 1));
  assign ph_wrap   = (phase_q == hp_q - 16'd1);
  assign sq_nx     = ph_wrap ? ~square_q : square_q;
  assign play_end  = (state_q == PLAY) && tick_wrap && (rem_q == 16'd1);

  // IDLE waits for the registered empty flag; LOAD/PLAY chain on the
  // live count so a chained pop never reads an empty FIFO.
  always_comb begin
    pop = 1'b0;
    if (!clear && avail) begin
      unique case (state_q)
        IDLE:    pop = !empty_q;
        LOAD:    pop = (rem_q == 16'd0);
        PLAY:    pop = play_end;
        default: pop = 1'b0;
      endcase
    end
  end

  assign cnt_d = cnt_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && full_int) ovf_q <= 1'b1;
      cnt_q   <= cnt_d;
      level_q <= cnt_q;
      empty_q <= (cnt_q == '0);
      full_q  <= full_int;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state_q  <= IDLE;
      hp_q     <= '0;
      rem_q    <= '0;
      phase_q  <= '0;
      presc_q  <= '0;
      square_q <= 1'b0;
      duty_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          duty_q <= '0;
          if (pop) begin
            hp_q    <= head[15:0];
            rem_q   <= head[31:16];
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          phase_q  <= '0;
          presc_q  <= '0;
          square_q <= 1'b1;
          if (rem_q == 16'd0) begin
            done_q <= 1'b1;
            duty_q <= '0;
            if (pop) begin
              hp_q  <= head[15:0];
              rem_q <= head[31:16];
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            state_q <= PLAY;
            duty_q  <= (hp_q != 16'd0) ? AMPLITUDE : 10'd0;
          end
        end
        PLAY: begin
          if (play_end) begin
            done_q <= 1'b1;
            duty_q <= '0;
            if (pop) begin
              hp_q    <= head[15:0];
              rem_q   <= head[31:16];
              state_q <= LOAD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            presc_q  <= tick_wrap ? '0 : presc_q + PW'(1);
            if (tick_wrap) rem_q <= rem_q - 16'd1;
            phase_q  <= ph_wrap ? 16'd0 : phase_q + 16'd1;
            square_q <= sq_nx;
            duty_q   <= (hp_q != 16'd0 && sq_nx) ? AMPLITUDE : 10'd0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          duty_q  <= '0;
        end
      endcase
    end
  end

  assign duty_cycle = duty_q;
  assign note_done  = done_q;
  assign busy       = busy_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign level      = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_audio_note_sequencer.sv
// tb_audio_note_sequencer: directed notes with a timed expectation queue.
// A negedge monitor pops and compares each entry on its due cycle.
module tb_audio_note_sequencer;

  localparam int TD = 4;
  localparam int F_DUTY  = 0;
  localparam int F_DONE  = 1;
  localparam int F_BUSY  = 2;
  localparam int F_EMPTY = 3;
  localparam int F_FULL  = 4;
  localparam int F_LEVEL = 5;
  localparam int F_OVF   = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        clear;
  logic [9:0]  duty_cycle;
  logic        note_done;
  logic        busy;
  logic        fifo_empty;
  logic        fifo_full;
  logic [3:0]  level;
  logic        overflow;

  audio_note_sequencer #(
    .FIFO_DEPTH(8),
    .TICK_DIV(TD),
    .AMPLITUDE(10'd512)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .clear(clear),
    .duty_cycle(duty_cycle),
    .note_done(note_done),
    .busy(busy),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    t;
    int    f;
    int    v;
    string nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   exp_pulses = 8;
  bit   fin = 1'b0;

  int s1 [8] = '{512, 512, 512, 0, 0, 0, 512, 512};
  int s2 [4] = '{512, 512, 0, 0};
  int s3 [4] = '{512, 0, 512, 0};

  function automatic int sample(int f);
    case (f)
      F_DUTY:  return int'(duty_cycle);
      F_DONE:  return int'(note_done);
      F_BUSY:  return int'(busy);
      F_EMPTY: return int'(fifo_empty);
      F_FULL:  return int'(fifo_full);
      F_LEVEL: return int'(level);
      default: return int'(overflow);
    endcase
  endfunction

  always @(negedge clk) begin
    if (note_done) pulses++;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].t == cyc) begin
        checks++;
        if (sample(q[i].f) != q[i].v) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %0d expected %0d",
                   q[i].nm, cyc, sample(q[i].f), q[i].v);
        end
        q.delete(i);
      end
    end
    if (fin) begin
      checks++;
      if (pulses != exp_pulses) begin
        errors++;
        $display("FAIL note_done_count: got %0d expected %0d",
                 pulses, exp_pulses);
      end
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL leftover_expectations: got %0d expected 0",
                 q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic ex(input int t, input int f, input int v, input string nm);
    exp_t e;
    e.t = t;
    e.f = f;
    e.v = v;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] w, output int e);
    wr_en   = 1'b1;
    wr_data = w;
    e       = cyc + 1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic waitto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int e0;
    int e1;
    int f0;
    int g0;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    clear   = 1'b0;
    wr_data = '0;

    ex(2, F_DUTY, 0, "rst_duty");
    ex(2, F_DONE, 0, "rst_done");
    ex(2, F_BUSY, 0, "rst_busy");
    ex(2, F_EMPTY, 1, "rst_empty");
    ex(2, F_FULL, 0, "rst_full");
    ex(2, F_LEVEL, 0, "rst_level");
    ex(2, F_OVF, 0, "rst_ovf");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // single note: dur=2 ticks, half-period 3
    wr(32'h0002_0003, e0);
    ex(e0 + 1, F_EMPTY, 0, "t1_empty_lag");
    ex(e0 + 1, F_LEVEL, 1, "t1_level");
    ex(e0 + 2, F_BUSY, 1, "t1_load_busy");
    ex(e0 + 2, F_DUTY, 0, "t1_load_duty");
    ex(e0 + 3, F_LEVEL, 0, "t1_level_pop");
    for (int i = 0; i < 8; i++) ex(e0 + 3 + i, F_DUTY, s1[i], "t1_duty");
    ex(e0 + 10, F_DONE, 0, "t1_done_early");
    ex(e0 + 11, F_DONE, 1, "t1_done");
    ex(e0 + 11, F_DUTY, 0, "t1_idle_duty");
    ex(e0 + 11, F_BUSY, 0, "t1_idle_busy");
    ex(e0 + 11, F_EMPTY, 1, "t1_idle_empty");
    ex(e0 + 12, F_DONE, 0, "t1_done_pulse");
    waitto(e0 + 13);

    // overflow behind a long note, then clear racing a write
    wr(32'h0064_03E8, e0);
    waitto(e0 + 4);
    f0 = cyc + 1;
    ex(f0 + 7, F_FULL, 0, "t2_full_early");
    ex(f0 + 7, F_OVF, 0, "t2_ovf_early");
    ex(f0 + 8, F_LEVEL, 8, "t2_level_top");
    ex(f0 + 8, F_FULL, 1, "t2_full");
    ex(f0 + 8, F_OVF, 1, "t2_ovf");
    ex(f0 + 8, F_DUTY, 512, "t2_playing");
    for (int i = 0; i < 9; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h0001_0001;
      @(negedge clk);
    end
    g0 = cyc + 1;
    ex(g0, F_LEVEL, 0, "t2_clr_level");
    ex(g0, F_OVF, 0, "t2_clr_ovf");
    ex(g0, F_DUTY, 0, "t2_clr_duty");
    ex(g0, F_BUSY, 0, "t2_clr_busy");
    ex(g0, F_EMPTY, 1, "t2_clr_empty");
    ex(g0, F_FULL, 0, "t2_clr_full");
    ex(g0, F_DONE, 0, "t2_clr_done");
    ex(g0 + 1, F_LEVEL, 0, "t2_clr_prio");
    ex(g0 + 4, F_BUSY, 0, "t2_stays_idle");
    clear   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 32'h0001_0001;
    @(negedge clk);
    clear = 1'b0;
    wr_en = 1'b0;
    waitto(g0 + 5);

    // gapless chain: tone then rest
    wr(32'h0001_0002, e0);
    wr(32'h0001_0000, e1);
    for (int i = 0; i < 4; i++) ex(e0 + 3 + i, F_DUTY, s2[i], "t3_tone");
    ex(e0 + 7, F_DUTY, 0, "t3_load_duty");
    ex(e0 + 7, F_DONE, 1, "t3_done1");
    ex(e0 + 7, F_BUSY, 1, "t3_load_busy");
    ex(e0 + 8, F_DONE, 0, "t3_done1_pulse");
    for (int i = 0; i < 4; i++) ex(e0 + 8 + i, F_DUTY, 0, "t3_rest");
    ex(e0 + 12, F_DONE, 1, "t3_done2");
    ex(e0 + 12, F_BUSY, 0, "t3_idle");
    waitto(e0 + 14);

    // zero-duration note followed by hp=1
    wr(32'h0000_0005, e0);
    wr(32'h0001_0001, e1);
    ex(e0 + 2, F_DONE, 0, "t4_load_nodone");
    ex(e0 + 3, F_DONE, 1, "t4_zero_done");
    ex(e0 + 3, F_BUSY, 1, "t4_reload_busy");
    ex(e0 + 3, F_DUTY, 0, "t4_reload_duty");
    for (int i = 0; i < 4; i++) ex(e0 + 4 + i, F_DUTY, s3[i], "t4_hp1");
    ex(e0 + 8, F_DONE, 1, "t4_done2");
    ex(e0 + 8, F_BUSY, 0, "t4_idle");
    ex(e0 + 8, F_DUTY, 0, "t4_idle_duty");
    waitto(e0 + 10);

    // push in the same cycle as the IDLE pop
    wr(32'h0001_0002, e0);
    ex(e0 + 1, F_LEVEL, 1, "t5_level_a");
    ex(e0 + 2, F_LEVEL, 1, "t5_level_b");
    ex(e0 + 3, F_LEVEL, 1, "t5_level_c");
    ex(e0 + 4, F_LEVEL, 1, "t5_level_d");
    for (int i = 0; i < 4; i++) ex(e0 + 3 + i, F_DUTY, s2[i], "t5_first");
    ex(e0 + 7, F_DONE, 1, "t5_done1");
    for (int i = 0; i < 4; i++) ex(e0 + 8 + i, F_DUTY, s3[i], "t5_second");
    ex(e0 + 12, F_DONE, 1, "t5_done2");
    ex(e0 + 12, F_EMPTY, 1, "t5_empty");
    @(negedge clk);
    wr(32'h0001_0001, e1);
    waitto(e0 + 14);

    // reset in the middle of a note
    wr(32'h0005_0007, e0);
    ex(e0 + 4, F_BUSY, 1, "t6_playing");
    ex(e0 + 5, F_DUTY, 512, "t6_duty_pre");
    ex(e0 + 6, F_DUTY, 0, "t6_rst_duty");
    ex(e0 + 6, F_BUSY, 0, "t6_rst_busy");
    ex(e0 + 6, F_LEVEL, 0, "t6_rst_level");
    ex(e0 + 6, F_DONE, 0, "t6_rst_done");
    ex(e0 + 7, F_DONE, 0, "t6_rst_nodone");
    waitto(e0 + 5);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr(32'h0001_0002, e1);
    for (int i = 0; i < 4; i++) ex(e1 + 3 + i, F_DUTY, s2[i], "t6_after");
    ex(e1 + 7, F_DONE, 1, "t6_done");
    ex(e1 + 7, F_BUSY, 0, "t6_idle");
    waitto(e1 + 9);

    fin = 1'b1;
  end

endmodule
